apb_mem_ws: RTL and testbench

Parametrised APB4 memory slave: byte-addressed, byte-lane-strobed RAM with configurable data width, depth, fixed wait-state insertion, registered (synchronous) read port and PSLVERR signalling for illegal accesses. Sits behind the AHB-to-APB bridge as the next-generation peripheral memory. It exercises bridge wait-state and error paths that a zero-wait, never-erroring memory cannot.

---
 rtl/apb_mem_ws.sv | 92 +++++++++
 tb/tb_apb_mem_ws.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_ws.sv
// APB4 memory slave with fixed wait-state insertion, byte-lane strobes,
// a registered read port and PSLVERR on out-of-range, misaligned or unprivileged accesses.
module apb_mem_ws #(
   parameter int DW            = 32,
   parameter int SIZE_IN_BYTES = 4096,
   parameter int WAIT_STATES   = 2,
   parameter bit PRIV_ONLY     = 1'b0
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   input  logic            PSEL,
   input  logic            PENABLE,
   input  logic [31:0]     PADDR,
   input  logic            PWRITE,
   input  logic [DW-1:0]   PWDATA,
   input  logic [DW/8-1:0] PSTRB,
   input  logic [2:0]      PPROT,
   output logic [DW-1:0]   PRDATA,
   output logic            PREADY,
   output logic            PSLVERR
);

   localparam int NB    = DW / 8;
   localparam int OFS   = $clog2(NB);
   localparam int AW    = $clog2(SIZE_IN_BYTES);
   localparam int WORDS = SIZE_IN_BYTES / NB;
   localparam logic [3:0] WS = WAIT_STATES[3:0];

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [DW-1:0]     mem [WORDS];
   logic [DW-1:0]     rdata_q;
   logic [AW-OFS-1:0] idx;
   logic              access, setup, addr_err, err, ready;
   logic              unused_prot;

   assign access      = PSEL & PENABLE;
   assign setup       = PSEL & ~PENABLE;
   assign idx         = PADDR[AW-1:OFS];
   assign addr_err    = (PADDR[31:AW] != '0) | (PADDR[OFS-1:0] != '0);
   assign err         = addr_err | (PRIV_ONLY & ~PPROT[0]);
   assign unused_prot = ^PPROT[2:1];

   // Gating with PRESETn keeps a zero-wait slave from completing (and writing) while held in reset.
   assign ready = PRESETn & access & (cnt == WS);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Any cycle that is not an access phase (idle or a fresh setup) restarts the wait count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!access || ready) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         cnt_nxt   = cnt + 4'd1;
         state_nxt = (cnt_nxt == WS) ? DONE : WAIT;
      end
   end

   always_comb begin
      PREADY  = ready;
      PSLVERR = ready & err;
      PRDATA  = (ready & ~PWRITE & ~err) ? rdata_q : '0;
   end

   always_ff @(posedge PCLK) begin
      if (ready && PWRITE && !err) begin
         for (int i = 0; i < NB; i++) begin
            if (PSTRB[i]) mem[idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
         end
      end
   end

   // Read data is fetched at the end of setup, so a write completing just before is already visible.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)  rdata_q <= '0;
      else if (setup) rdata_q <= addr_err ? '0 : mem[idx];
   end

endmodule

// File: tb/tb_apb_mem_ws.sv
// Directed table-driven bench for apb_mem_ws: three instances (DW32/WS2, DW32/WS1 privileged-only,
// DW64/WS0) share one APB bus, with sel choosing which slave is addressed and observed.
module tb_apb_mem_ws;

   logic        PCLK, PRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR;
   logic [63:0] PWDATA;
   logic [7:0]  PSTRB;
   logic [2:0]  PPROT;
   int          sel;

   logic [31:0] prdataA, prdataB;
   logic [63:0] prdataC;
   logic        preadyA, preadyB, preadyC;
   logic        slverrA, slverrB, slverrC;
   logic        pselA, pselB, pselC;
   logic [63:0] rdataMux;
   logic        readyMux, slverrMux;

   int checks = 0;
   int errors = 0;

   assign pselA = PSEL && (sel == 0);
   assign pselB = PSEL && (sel == 1);
   assign pselC = PSEL && (sel == 2);

   apb_mem_ws #(.DW(32), .SIZE_IN_BYTES(4096), .WAIT_STATES(2), .PRIV_ONLY(1'b0)) dutA (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(pselA), .PENABLE(PENABLE), .PADDR(PADDR),
      .PWRITE(PWRITE), .PWDATA(PWDATA[31:0]), .PSTRB(PSTRB[3:0]), .PPROT(PPROT),
      .PRDATA(prdataA), .PREADY(preadyA), .PSLVERR(slverrA));

   apb_mem_ws #(.DW(32), .SIZE_IN_BYTES(4096), .WAIT_STATES(1), .PRIV_ONLY(1'b1)) dutB (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(pselB), .PENABLE(PENABLE), .PADDR(PADDR),
      .PWRITE(PWRITE), .PWDATA(PWDATA[31:0]), .PSTRB(PSTRB[3:0]), .PPROT(PPROT),
      .PRDATA(prdataB), .PREADY(preadyB), .PSLVERR(slverrB));

   apb_mem_ws #(.DW(64), .SIZE_IN_BYTES(4096), .WAIT_STATES(0), .PRIV_ONLY(1'b0)) dutC (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(pselC), .PENABLE(PENABLE), .PADDR(PADDR),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
      .PRDATA(prdataC), .PREADY(preadyC), .PSLVERR(slverrC));

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   always_comb begin
      rdataMux  = '0;
      readyMux  = 1'b0;
      slverrMux = 1'b0;
      case (sel)
         0: begin rdataMux = {32'h0, prdataA}; readyMux = preadyA; slverrMux = slverrA; end
         1: begin rdataMux = {32'h0, prdataB}; readyMux = preadyB; slverrMux = slverrB; end
         default: begin rdataMux = prdataC; readyMux = preadyC; slverrMux = slverrC; end
      endcase
   end

   typedef struct {
      int          sel;
      logic        write;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [2:0]  prot;
      int          expWaits;
      logic [63:0] expRdata;
      logic        expErr;
      logic        idle;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input int s, input logic w, input logic [31:0] a,
                                  input logic [63:0] d, input logic [7:0] st, input logic [2:0] p,
                                  input int ew, input logic [63:0] er, input logic ee, input logic idl);
      vec_t v;
      v.sel = s; v.write = w; v.addr = a; v.wdata = d; v.strb = st; v.prot = p;
      v.expWaits = ew; v.expRdata = er; v.expErr = ee; v.idle = idl;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Entered just after a clock edge; leaves just after the edge that ends the PREADY cycle.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [63:0] d,
                                input logic [7:0] st, input logic [2:0] p,
                                output int waits, output logic [63:0] rdata,
                                output logic slverr, output logic seen);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = st; PPROT = p;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      waits = 0; seen = 1'b0; rdata = '0; slverr = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge PCLK);
         if (readyMux) begin
            seen = 1'b1; rdata = rdataMux; slverr = slverrMux;
         end else begin
            waits++;
         end
         @(posedge PCLK); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   initial begin
      int          waits;
      logic [63:0] rdata;
      logic        slverr, seen;

      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; sel = 2;

      // Zero-wait slave sees an access phase while held in reset: it must not complete.
      #3;
      PSEL = 1'b1; PENABLE = 1'b1;
      #1;
      checkOutput("reset PREADY", {63'h0, readyMux}, 64'h0);
      checkOutput("reset PSLVERR", {63'h0, slverrMux}, 64'h0);
      checkOutput("reset PRDATA", rdataMux, 64'h0);
      repeat (2) @(posedge PCLK);
      #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      // Writes of all ones stand in for the power-up byte pattern of 0xFF.
      addVec(0, 1, 32'h010, 64'hDEADBEEF, 8'hF, 3'b000, 2, 64'h0, 0, 1);
      addVec(0, 0, 32'h010, 64'h0,        8'h0, 3'b000, 2, 64'hDEADBEEF, 0, 0);
      addVec(0, 1, 32'h020, 64'hFFFFFFFF, 8'hF, 3'b000, 2, 64'h0, 0, 0);
      addVec(0, 1, 32'h020, 64'h11223344, 8'h5, 3'b000, 2, 64'h0, 0, 0);
      addVec(0, 0, 32'h020, 64'h0,        8'h0, 3'b000, 2, 64'hFF22FF44, 0, 1);
      addVec(0, 0, 32'h1000, 64'h0,       8'h0, 3'b000, 2, 64'h0, 1, 0);
      addVec(0, 1, 32'h000, 64'hA5A5A5A5, 8'hF, 3'b000, 2, 64'h0, 0, 0);
      addVec(0, 1, 32'h002, 64'h12345678, 8'hF, 3'b000, 2, 64'h0, 1, 0);
      addVec(0, 0, 32'h000, 64'h0,        8'h0, 3'b000, 2, 64'hA5A5A5A5, 0, 0);
      addVec(0, 0, 32'h002, 64'h0,        8'h0, 3'b000, 2, 64'h0, 1, 0);
      addVec(0, 1, 32'hFFC, 64'h87654321, 8'hF, 3'b000, 2, 64'h0, 0, 0);
      addVec(0, 0, 32'hFFC, 64'h0,        8'h0, 3'b000, 2, 64'h87654321, 0, 1);
      addVec(1, 1, 32'h040, 64'h00000000, 8'hF, 3'b001, 1, 64'h0, 0, 0);
      addVec(1, 1, 32'h040, 64'h55AA55AA, 8'hF, 3'b000, 1, 64'h0, 1, 0);
      addVec(1, 0, 32'h040, 64'h0,        8'h0, 3'b001, 1, 64'h0, 0, 0);
      addVec(1, 1, 32'h040, 64'h55AA55AA, 8'hF, 3'b001, 1, 64'h0, 0, 0);
      addVec(1, 0, 32'h040, 64'h0,        8'h0, 3'b001, 1, 64'h55AA55AA, 0, 0);
      addVec(1, 0, 32'h040, 64'h0,        8'h0, 3'b000, 1, 64'h0, 1, 1);
      addVec(2, 1, 32'h008, 64'h0123456789ABCDEF, 8'hFF, 3'b000, 0, 64'h0, 0, 0);
      addVec(2, 0, 32'h008, 64'h0,        8'h00, 3'b000, 0, 64'h0123456789ABCDEF, 0, 0);
      addVec(2, 1, 32'h010, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 3'b000, 0, 64'h0, 0, 0);
      addVec(2, 1, 32'h010, 64'h0011223344556677, 8'h0F, 3'b000, 0, 64'h0, 0, 0);
      addVec(2, 0, 32'h010, 64'h0,        8'h00, 3'b000, 0, 64'hFFFFFFFF44556677, 0, 0);
      addVec(2, 0, 32'h004, 64'h0,        8'h00, 3'b000, 0, 64'h0, 1, 0);
      addVec(2, 0, 32'h1000, 64'h0,       8'h00, 3'b000, 0, 64'h0, 1, 1);

      foreach (vecs[i]) begin
         sel = vecs[i].sel;
         applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot,
                       waits, rdata, slverr, seen);
         checkOutput($sformatf("v%0d pready_seen", i), {63'h0, seen}, 64'h1);
         checkOutput($sformatf("v%0d waits", i), 64'(waits), 64'(vecs[i].expWaits));
         checkOutput($sformatf("v%0d pslverr", i), {63'h0, slverr}, {63'h0, vecs[i].expErr});
         checkOutput($sformatf("v%0d prdata", i), rdata, vecs[i].expRdata);
         if (vecs[i].idle) begin
            @(posedge PCLK); #1;
         end
      end

      // Reset during the second access cycle of a write must abort it.
      sel = 0;
      applyStimulus(1'b1, 32'h030, 64'hCAFEF00D, 8'hF, 3'b000, waits, rdata, slverr, seen);
      checkOutput("rst pre-write pslverr", {63'h0, slverr}, 64'h0);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h030;
      PWDATA = 64'h12345678; PSTRB = 8'hF; PPROT = 3'b000;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      #1;
      checkOutput("rst async PREADY", {63'h0, readyMux}, 64'h0);
      checkOutput("rst async PSLVERR", {63'h0, slverrMux}, 64'h0);
      checkOutput("rst async PRDATA", rdataMux, 64'h0);
      for (int c = 0; c < 2; c++) begin
         @(negedge PCLK);
         checkOutput($sformatf("rst hold%0d PREADY", c), {63'h0, readyMux}, 64'h0);
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      #2;
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      applyStimulus(1'b0, 32'h030, 64'h0, 8'h0, 3'b000, waits, rdata, slverr, seen);
      checkOutput("rst readback seen", {63'h0, seen}, 64'h1);
      checkOutput("rst readback waits", 64'(waits), 64'd2);
      checkOutput("rst readback prdata", rdata, 64'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
